pmem_arbiter: RTL and testbench

Parametrised physical-memory arbiter that lets `NUM_CLIENTS` line-granular cache clients share one physical-memory port. It sits between the cache hierarchy's miss/writeback paths (I-cache, D-cache, L2, prefetcher) and the `pmem_*` interface at the top level. It serialises whole-line read and write transactions, holds one grant until memory responds, and returns the response to the granted client only.

---
 rtl/pmem_arbiter.sv | 156 +++++++++++++++
 tb/tb_pmem_arbiter.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : pmem_arbiter
// Purpose  : Shares one line-granular physical-memory port among NUM_CLIENTS
//            cache clients. Define PMEM_ARB_ROUND_ROBIN_EN for round-robin
//            arbitration; otherwise fixed priority (lowest index wins).
// Revision : 1.0 - initial release
// ============================================================================
module pmem_arbiter #(
  parameter int NUM_CLIENTS = 2,
  parameter int LINE_WIDTH  = 256,
  parameter int ADDR_WIDTH  = 32
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic [NUM_CLIENTS-1:0]            client_read,
  input  logic [NUM_CLIENTS-1:0]            client_write,
  input  logic [NUM_CLIENTS*ADDR_WIDTH-1:0] client_address,
  input  logic [NUM_CLIENTS*LINE_WIDTH-1:0] client_wdata,
  output logic [LINE_WIDTH-1:0]             client_rdata,
  output logic [NUM_CLIENTS-1:0]            client_resp,
  input  logic                              pmem_resp,
  input  logic [LINE_WIDTH-1:0]             pmem_rdata,
  output logic                              pmem_read,
  output logic                              pmem_write,
  output logic [ADDR_WIDTH-1:0]             pmem_address,
  output logic [LINE_WIDTH-1:0]             pmem_wdata
);

  localparam int c_IDX_W = $clog2(NUM_CLIENTS);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ISSUE   = 2'd1,
    RESPOND = 2'd2
  } state_t;

  state_t                 r_state;
  state_t                 w_state_next;
  logic [c_IDX_W-1:0]     r_grant;
  logic                   r_op_write;
  logic [ADDR_WIDTH-1:0]  r_addr;
  logic [LINE_WIDTH-1:0]  r_wdata;
  logic [LINE_WIDTH-1:0]  r_rdata;

  logic [NUM_CLIENTS-1:0] w_req;
  logic [c_IDX_W-1:0]     w_lo;
  logic [c_IDX_W-1:0]     w_win;
  logic [ADDR_WIDTH-1:0]  w_addr_arr  [NUM_CLIENTS];
  logic [LINE_WIDTH-1:0]  w_wdata_arr [NUM_CLIENTS];

  assign w_req = client_read | client_write;

  generate
    for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_unpack
      assign w_addr_arr[g]  = client_address[g*ADDR_WIDTH +: ADDR_WIDTH];
      assign w_wdata_arr[g] = client_wdata[g*LINE_WIDTH +: LINE_WIDTH];
    end
  endgenerate

  // Lowest-index requester: the fixed-priority winner and the round-robin wrap-around case.
  always_comb begin
    w_lo = '0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (w_req[i]) w_lo = c_IDX_W'(i);
    end
  end

`ifdef PMEM_ARB_ROUND_ROBIN_EN
  logic [c_IDX_W-1:0] r_last;
  logic [c_IDX_W-1:0] w_hi;
  logic               w_hi_vld;

  // Lowest requester strictly above the last grant; fall back to the lowest overall.
  always_comb begin
    w_hi     = '0;
    w_hi_vld = 1'b0;
    for (int i = NUM_CLIENTS - 1; i >= 0; i--) begin
      if (w_req[i] && (c_IDX_W'(i) > r_last)) begin
        w_hi     = c_IDX_W'(i);
        w_hi_vld = 1'b1;
      end
    end
  end

  assign w_win = w_hi_vld ? w_hi : w_lo;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last <= c_IDX_W'(NUM_CLIENTS - 1);
    end else if ((r_state == IDLE) && (|w_req)) begin
      r_last <= w_win;
    end
  end
`else
  assign w_win = w_lo;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (|w_req) w_state_next = ISSUE;
      ISSUE:   if (pmem_resp) w_state_next = RESPOND;
      RESPOND: w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  // Transaction registers: client inputs are only looked at in IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_grant    <= '0;
      r_op_write <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_rdata    <= '0;
    end else begin
      if ((r_state == IDLE) && (|w_req)) begin
        r_grant    <= w_win;
        r_op_write <= client_write[w_win];
        r_addr     <= w_addr_arr[w_win];
        r_wdata    <= w_wdata_arr[w_win];
      end
      if ((r_state == ISSUE) && pmem_resp) begin
        r_rdata <= pmem_rdata;
      end
    end
  end

  always_comb begin
    pmem_read   = 1'b0;
    pmem_write  = 1'b0;
    client_resp = '0;
    if (r_state == ISSUE) begin
      pmem_read  = ~r_op_write;
      pmem_write = r_op_write;
    end
    if (r_state == RESPOND) begin
      client_resp = NUM_CLIENTS'(1) << r_grant;
    end
  end

  assign pmem_address = r_addr;
  assign pmem_wdata   = r_wdata;
  assign client_rdata = r_rdata;

endmodule
`default_nettype wire

// File: tb/tb_pmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_pmem_arbiter
// Purpose  : Self-checking bench for pmem_arbiter with a transaction-level
//            model and a latency-programmable memory responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pmem_arbiter;

  localparam int N  = 3;
  localparam int AW = 32;
  localparam int LW = 64;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [N-1:0]    client_read;
  logic [N-1:0]    client_write;
  logic [N*AW-1:0] client_address;
  logic [N*LW-1:0] client_wdata;
  logic [LW-1:0]   client_rdata;
  logic [N-1:0]    client_resp;
  logic            pmem_resp;
  logic [LW-1:0]   pmem_rdata;
  logic            pmem_read;
  logic            pmem_write;
  logic [AW-1:0]   pmem_address;
  logic [LW-1:0]   pmem_wdata;

  pmem_arbiter #(.NUM_CLIENTS(N), .LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .client_read(client_read), .client_write(client_write),
    .client_address(client_address), .client_wdata(client_wdata),
    .client_rdata(client_rdata), .client_resp(client_resp),
    .pmem_resp(pmem_resp), .pmem_rdata(pmem_rdata),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string nm, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // Winner = first requester in the order last+1, last+2, ... (mod N); -1 if none.
  function automatic int pick(input logic [N-1:0] req, input int last);
    int best_d = N;
    int w = -1;
    for (int c = 0; c < N; c++) begin
      int d = (c - last - 1 + 2 * N) % N;
      if (req[c] && d < best_d) begin
        best_d = d;
        w = c;
      end
    end
    return w;
  endfunction

  // Transaction-level model: idle / in flight at memory / completion cycle.
  int            m_phase;
  int            m_client;
  logic          m_write;
  logic [AW-1:0] m_addr;
  logic [LW-1:0] m_wdata;
  logic [LW-1:0] m_rdata;
  int            m_pick;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
  int            m_last;
  assign m_pick = pick(client_read | client_write, m_last);
`else
  assign m_pick = pick(client_read | client_write, N - 1);
`endif

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase <= 0;
      m_rdata <= '0;
`ifdef PMEM_ARB_ROUND_ROBIN_EN
      m_last  <= N - 1;
`endif
    end else if (m_phase == 0) begin
      if (m_pick >= 0) begin
        m_phase  <= 1;
        m_client <= m_pick;
        m_write  <= client_write[m_pick];
        m_addr   <= client_address[m_pick*AW +: AW];
        m_wdata  <= client_wdata[m_pick*LW +: LW];
`ifdef PMEM_ARB_ROUND_ROBIN_EN
        m_last   <= m_pick;
`endif
      end
    end else if (m_phase == 1) begin
      if (pmem_resp) begin
        m_phase <= 2;
        m_rdata <= pmem_rdata;
      end
    end else begin
      m_phase <= 0;
    end
  end

  // Observed history used by the directed literal checks.
  int            resp_count = 0;
  int            rd_cycles  = 0;
  int            wr_cycles  = 0;
  int            grants[$];
  logic [N-1:0]  last_resp;
  logic [LW-1:0] last_rdata;

  initial begin
    forever begin
      @(negedge clk);
      if (rst_n) begin
        logic [N-1:0] e_resp;
        e_resp = '0;
        if (m_phase == 2) e_resp[m_client] = 1'b1;
        chk("pmem_read",   LW'(pmem_read),   LW'(m_phase == 1 && !m_write));
        chk("pmem_write",  LW'(pmem_write),  LW'(m_phase == 1 && m_write));
        chk("client_resp", LW'(client_resp), LW'(e_resp));
        if (m_phase == 1) begin
          chk("pmem_address", LW'(pmem_address), LW'(m_addr));
          if (m_write) chk("pmem_wdata", pmem_wdata, m_wdata);
        end
        if (m_phase == 2) chk("client_rdata", client_rdata, m_rdata);
        if (pmem_read)  rd_cycles++;
        if (pmem_write) wr_cycles++;
        if (client_resp != '0) begin
          resp_count++;
          last_resp  = client_resp;
          last_rdata = client_rdata;
          for (int c = 0; c < N; c++) if (client_resp[c]) grants.push_back(c);
        end
      end
    end
  end

  // Memory responder: pulses pmem_resp after mem_lat command cycles.
  int            mem_lat = 1;
  int            mem_cnt = 0;
  bit            stray   = 1'b0;
  initial begin
    pmem_resp = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mem_cnt   = 0;
        pmem_resp = 1'b0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        mem_cnt   = 0;
      end else if (stray) begin
        pmem_resp = 1'b1;
        stray     = 1'b0;
      end else if (pmem_read || pmem_write) begin
        mem_cnt++;
        if (mem_cnt >= mem_lat) begin
          pmem_resp = 1'b1;
          mem_cnt   = 0;
        end
      end
    end
  end

  task automatic clear_reqs();
    client_read    = '0;
    client_write   = '0;
    client_address = '0;
    client_wdata   = '0;
  endtask

  task automatic do_req(input int c, input bit rd, input bit wr, input logic [AW-1:0] addr,
                        input logic [LW-1:0] wdata, input int lat, input logic [LW-1:0] rdata);
    int n0;
    @(posedge clk); #2;
    mem_lat   = lat;
    pmem_rdata = rdata;
    rd_cycles = 0;
    wr_cycles = 0;
    n0 = resp_count;
    client_read[c]            = rd;
    client_write[c]           = wr;
    client_address[c*AW +: AW] = addr;
    client_wdata[c*LW +: LW]   = wdata;
    for (int k = 0; k < 40 && resp_count == n0; k++) begin
      @(posedge clk); #2;
    end
    chk("resp_count", LW'(resp_count - n0), LW'(1));
    clear_reqs();
  endtask

  initial begin
    int n0;
    int g0;
    int exp_g[4];
    rst_n      = 1'b0;
    pmem_rdata = '0;
    clear_reqs();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_pmem_read",    LW'(pmem_read),    '0);
    chk("rst_pmem_write",   LW'(pmem_write),   '0);
    chk("rst_client_resp",  LW'(client_resp),  '0);
    chk("rst_client_rdata", client_rdata,      '0);
    chk("rst_pmem_address", LW'(pmem_address), '0);
    chk("rst_pmem_wdata",   pmem_wdata,        '0);
    @(negedge clk);
    rst_n = 1'b1;

    // Single read from client 1, four-cycle memory latency.
    do_req(1, 1'b1, 1'b0, 32'h0000_1240, '0, 4, {8{8'hA5}});
    chk("read_cycles", LW'(rd_cycles),  LW'(4));
    chk("read_resp",   LW'(last_resp),  LW'(3'b010));
    chk("read_rdata",  last_rdata,      {8{8'hA5}});

    // Write from client 0.
    do_req(0, 1'b0, 1'b1, 32'h0000_0800, {4{16'h1234}}, 2, '0);
    chk("write_cycles",     LW'(wr_cycles), LW'(2));
    chk("write_read_quiet", LW'(rd_cycles), LW'(0));
    chk("write_resp",       LW'(last_resp), LW'(3'b001));

    // Stray memory response while idle.
    @(posedge clk); #2;
    n0 = resp_count;
    stray = 1'b1;
    repeat (4) @(posedge clk);
    #2;
    chk("stray_no_resp", LW'(resp_count - n0), LW'(0));
    chk("stray_no_cmd",  LW'(pmem_read | pmem_write), LW'(0));
    do_req(0, 1'b1, 1'b0, 32'h0000_0040, '0, 2, {4{16'hBEEF}});
    chk("post_stray_cycles", LW'(rd_cycles), LW'(2));
    chk("post_stray_rdata",  last_rdata,     {4{16'hBEEF}});

    // Read and write together on client 2: write wins.
    do_req(2, 1'b1, 1'b1, 32'h0000_2000, {2{32'hC0FFEE00}}, 3, '0);
    chk("rdwr_write_cycles", LW'(wr_cycles), LW'(3));
    chk("rdwr_read_cycles",  LW'(rd_cycles), LW'(0));
    chk("rdwr_resp",         LW'(last_resp), LW'(3'b100));

    // Contention: all three clients hold read requests.
    @(posedge clk); #2;
    g0 = grants.size();
    n0 = resp_count;
    mem_lat    = 1;
    pmem_rdata = {8{8'h3C}};
    client_read    = '1;
    client_address = {32'h0000_0300, 32'h0000_0200, 32'h0000_0100};
    for (int k = 0; k < 60 && (resp_count - n0) < 4; k++) begin
      @(posedge clk); #2;
    end
    clear_reqs();
    chk("contention_count", LW'(resp_count - n0), LW'(4));
`ifdef PMEM_ARB_ROUND_ROBIN_EN
    exp_g = '{0, 1, 2, 0};
`else
    exp_g = '{0, 0, 0, 0};
`endif
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("grant%0d", i), LW'(grants[g0 + i]), LW'(exp_g[i]));
    end

    // Reset asserted while a read is in flight.
    @(posedge clk); #2;
    mem_lat        = 20;
    client_read[1] = 1'b1;
    client_address[1*AW +: AW] = 32'h0000_5550;
    repeat (3) @(posedge clk);
    #2;
    chk("pre_reset_read", LW'(pmem_read), LW'(1));
    rst_n = 1'b0;
    #1;
    chk("arst_pmem_read",    LW'(pmem_read),    '0);
    chk("arst_pmem_write",   LW'(pmem_write),   '0);
    chk("arst_client_resp",  LW'(client_resp),  '0);
    chk("arst_client_rdata", client_rdata,      '0);
    chk("arst_pmem_address", LW'(pmem_address), '0);
    clear_reqs();
    n0 = resp_count;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(posedge clk);
    #2;
    chk("post_reset_no_resp", LW'(resp_count - n0), LW'(0));
    chk("post_reset_read",    LW'(pmem_read),        LW'(0));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
